// File: rtl/add3_rr_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : add3_rr_scheduler
// Desc     : Round-robin issue of operand triples from NREQ requesters to one
//            shared 3-operand adder; tags each issue and routes the result
//            back as a one-cycle strobe.
//            Optional build macro ADD3_RR_SAT_EN: unsigned saturation of the
//            result when the adder reports carry.
// Revision : 1.0 - initial release
// =============================================================================
module add3_rr_scheduler #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 0
) (
  input  logic                  i_clkp,
  input  logic                  i_rstn,
  input  logic                  i_en,
  input  logic [NREQ-1:0]       i_req_vld,
  input  logic [NREQ*WIDTH-1:0] i_req_z,
  input  logic [NREQ*WIDTH-1:0] i_req_a,
  input  logic [NREQ*WIDTH-1:0] i_req_b,
  output logic [NREQ-1:0]       o_req_rdy,
  output logic [WIDTH-1:0]      o_add_z,
  output logic [WIDTH-1:0]      o_add_a,
  output logic [WIDTH-1:0]      o_add_b,
  output logic                  o_add_vld,
  input  logic [WIDTH-1:0]      i_add_d,
  input  logic                  i_add_c,
  output logic [NREQ-1:0]       o_res_vld,
  output logic [WIDTH-1:0]      o_res_d,
  output logic                  o_res_c,
  output logic                  o_busy
);

  localparam int c_ptr_w = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_pos_w = c_ptr_w + 1;
  localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(NREQ - 1);
  localparam logic [c_pos_w-1:0] c_nreq = c_pos_w'(NREQ);

  logic [c_ptr_w-1:0] r_ptr;
  logic [WIDTH-1:0]   r_add_z;
  logic [WIDTH-1:0]   r_add_a;
  logic [WIDTH-1:0]   r_add_b;
  logic               r_add_vld;
  logic [ADD_LAT:0]   r_tag_vld;
  logic [c_ptr_w-1:0] r_tag_idx [0:ADD_LAT];
  logic [NREQ-1:0]    r_res_vld;
  logic [WIDTH-1:0]   r_res_d;
  logic               r_res_c;

  logic [NREQ-1:0]    w_rot;
  logic [c_pos_w-1:0] w_pos;
  logic [c_ptr_w-1:0] w_gidx;
  logic [c_ptr_w-1:0] w_ptr_nxt;
  logic               w_found;
  logic               w_xfer;
  logic [NREQ-1:0]    w_grant;
  logic [WIDTH-1:0]   w_sel_z;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic               w_tag_last;
  logic [WIDTH-1:0]   w_res_d;

  // Rotate the request vector so bit 0 is the requester at the rr pointer;
  // the first set bit then gives the offset from the pointer to the winner.
  assign w_rot = NREQ'({i_req_vld, i_req_vld} >> r_ptr);

  always_comb begin
    w_found = 1'b0;
    w_pos   = '0;
    w_gidx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_pos   = {1'b0, r_ptr} + c_pos_w'(i);
      end
    end
    if (w_pos >= c_nreq) begin
      w_gidx = c_ptr_w'(w_pos - c_nreq);
    end else begin
      w_gidx = w_pos[c_ptr_w-1:0];
    end
  end

  assign w_grant   = w_found ? (NREQ'(1) << w_gidx) : '0;
  assign o_req_rdy = i_en ? w_grant : '0;
  assign w_xfer    = |(i_req_vld & o_req_rdy);
  assign w_ptr_nxt = (w_gidx == c_last) ? '0 : w_gidx + c_ptr_w'(1);

  always_comb begin
    w_sel_z = '0;
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_gidx == c_ptr_w'(k)) begin
        w_sel_z = i_req_z[k*WIDTH +: WIDTH];
        w_sel_a = i_req_a[k*WIDTH +: WIDTH];
        w_sel_b = i_req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  // Issue stage: operands hold between issues so the adder inputs stay quiet.
  always_ff @(posedge i_clkp or negedge i_rstn) begin
    if (!i_rstn) begin
      r_ptr     <= '0;
      r_add_z   <= '0;
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_add_vld <= 1'b0;
    end else begin
      r_add_vld <= w_xfer;
      if (w_xfer) begin
        r_ptr   <= w_ptr_nxt;
        r_add_z <= w_sel_z;
        r_add_a <= w_sel_a;
        r_add_b <= w_sel_b;
      end
    end
  end

  // Tag pipe mirrors the adder latency; the last stage lines up with i_add_d.
  always_ff @(posedge i_clkp or negedge i_rstn) begin
    if (!i_rstn) begin
      r_tag_vld <= '0;
      for (int s = 0; s <= ADD_LAT; s++) begin
        r_tag_idx[s] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_xfer;
      r_tag_idx[0] <= w_gidx;
      for (int s = 1; s <= ADD_LAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_idx[s] <= r_tag_idx[s-1];
      end
    end
  end

  assign w_tag_last = r_tag_vld[ADD_LAT];

`ifdef ADD3_RR_SAT_EN
  assign w_res_d = i_add_c ? '1 : i_add_d;
`else
  assign w_res_d = i_add_d;
`endif

  always_ff @(posedge i_clkp or negedge i_rstn) begin
    if (!i_rstn) begin
      r_res_vld <= '0;
      r_res_d   <= '0;
      r_res_c   <= 1'b0;
    end else begin
      r_res_vld <= w_tag_last ? (NREQ'(1) << r_tag_idx[ADD_LAT]) : '0;
      if (w_tag_last) begin
        r_res_d <= w_res_d;
        r_res_c <= i_add_c;
      end
    end
  end

  assign o_add_z   = r_add_z;
  assign o_add_a   = r_add_a;
  assign o_add_b   = r_add_b;
  assign o_add_vld = r_add_vld;
  assign o_res_vld = r_res_vld;
  assign o_res_d   = r_res_d;
  assign o_res_c   = r_res_c;
  assign o_busy    = r_add_vld | (|r_tag_vld);

endmodule
`default_nettype wire

// File: tb/tb_add3_rr_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : tb_add3_rr_scheduler
// Desc     : Directed bench driving two scheduler instances (adder latency 0
//            and 2) from one stimulus stream, checked against a history model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_add3_rr_scheduler;
  localparam int W    = 32;
  localparam int N    = 4;
  localparam int MAXC = 1024;
`ifdef ADD3_RR_SAT_EN
  localparam logic [W-1:0] c_ovf_d = 32'hFFFF_FFFF;
`else
  localparam logic [W-1:0] c_ovf_d = 32'hFFFF_FFFD;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b0;
  logic [N-1:0] vld = '0;
  logic [N*W-1:0] rz = '0, ra = '0, rb = '0;

  logic [N-1:0] rdy0, rv0, rdy2, rv2;
  logic [W-1:0] az0, aa0, ab0, rd0, ad0, az2, aa2, ab2, rd2, ad2;
  logic av0, rc0, bsy0, ac0, av2, rc2, bsy2, ac2;
  logic [W+1:0] s0, p1, p2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mptr = 0;
  int last_rst = -1;
  bit hold_all = 1'b0;
  logic [N-1:0] pend = '0;
  logic [N-1:0] clr = '0;
  bit xv [MAXC];
  int xi [MAXC];
  logic [W-1:0] xz [MAXC], xa [MAXC], xb [MAXC], xd [MAXC];
  bit xc [MAXC];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W+1:0] add3(input logic [W-1:0] z, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    return {2'b00, z} + {2'b00, a} + {2'b00, b};
  endfunction

  // External adders: combinational for latency 0, two register stages for latency 2.
  assign s0  = add3(az0, aa0, ab0);
  assign ad0 = s0[W-1:0];
  assign ac0 = |s0[W+1:W];
  always @(posedge clk) begin
    p1 <= add3(az2, aa2, ab2);
    p2 <= p1;
  end
  assign ad2 = p2[W-1:0];
  assign ac2 = |p2[W+1:W];

  add3_rr_scheduler #(.WIDTH(W), .NREQ(N), .ADD_LAT(0)) u_dut_l0 (
    .i_clkp(clk), .i_rstn(rstn), .i_en(en), .i_req_vld(vld),
    .i_req_z(rz), .i_req_a(ra), .i_req_b(rb), .o_req_rdy(rdy0),
    .o_add_z(az0), .o_add_a(aa0), .o_add_b(ab0), .o_add_vld(av0),
    .i_add_d(ad0), .i_add_c(ac0), .o_res_vld(rv0), .o_res_d(rd0),
    .o_res_c(rc0), .o_busy(bsy0)
  );

  add3_rr_scheduler #(.WIDTH(W), .NREQ(N), .ADD_LAT(2)) u_dut_l2 (
    .i_clkp(clk), .i_rstn(rstn), .i_en(en), .i_req_vld(vld),
    .i_req_z(rz), .i_req_a(ra), .i_req_b(rb), .o_req_rdy(rdy2),
    .o_add_z(az2), .o_add_a(aa2), .o_add_b(ab2), .o_add_vld(av2),
    .i_add_d(ad2), .i_add_c(ac2), .o_res_vld(rv2), .o_res_d(rd2),
    .o_res_c(rc2), .o_busy(bsy2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pick(input int p, input logic [N-1:0] v, input logic e);
    if (!e) return -1;
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  // Expected registered outputs in cycle c, derived only from the transfer history.
  task automatic chk_dut(input int lat, input string nm, input logic avld,
                         input logic [W-1:0] az, input logic [W-1:0] aa, input logic [W-1:0] ab,
                         input logic [N-1:0] rv, input logic [W-1:0] rd, input logic rc,
                         input logic bsy);
    int c;
    logic e_avld, e_rc, e_bsy;
    logic [W-1:0] e_az, e_aa, e_ab, e_rd;
    logic [N-1:0] e_rv;
    c = cyc;
    e_avld = 1'b0; e_rc = 1'b0; e_bsy = 1'b0;
    e_az = '0; e_aa = '0; e_ab = '0; e_rd = '0; e_rv = '0;
    for (int t = c - 1; t > last_rst && t >= 0; t--) begin
      if (xv[t]) begin
        e_avld = (t == c - 1);
        e_az = xz[t]; e_aa = xa[t]; e_ab = xb[t];
        break;
      end
    end
    for (int t = c - lat - 2; t > last_rst && t >= 0; t--) begin
      if (xv[t]) begin
        if (t == c - lat - 2) e_rv = N'(1) << xi[t];
        e_rd = xd[t];
        e_rc = xc[t];
`ifdef ADD3_RR_SAT_EN
        if (xc[t]) e_rd = '1;
`endif
        break;
      end
    end
    for (int t = c - 1 - lat; t <= c - 1; t++) begin
      if (t > last_rst && t >= 0 && xv[t]) e_bsy = 1'b1;
    end
    chk({nm, "_add_vld"}, avld, e_avld);
    chk({nm, "_add_z"}, az, e_az);
    chk({nm, "_add_a"}, aa, e_aa);
    chk({nm, "_add_b"}, ab, e_ab);
    chk({nm, "_res_vld"}, rv, e_rv);
    chk({nm, "_res_d"}, rd, e_rd);
    chk({nm, "_res_c"}, rc, e_rc);
    chk({nm, "_busy"}, bsy, e_bsy);
  endtask

  always @(negedge clk) begin : compare
    int k;
    logic [N-1:0] er;
    logic [W+1:0] s;
    if (!rstn) begin
      last_rst = cyc;
      mptr = 0;
    end
    k = pick(mptr, vld, en);
    er = (k >= 0) ? (N'(1) << k) : '0;
    chk("l0_rdy", rdy0, er);
    chk("l2_rdy", rdy2, er);
    if (rstn && k >= 0) begin
      xv[cyc] = 1'b1;
      xi[cyc] = k;
      xz[cyc] = rz[k*W +: W];
      xa[cyc] = ra[k*W +: W];
      xb[cyc] = rb[k*W +: W];
      s = add3(xz[cyc], xa[cyc], xb[cyc]);
      xd[cyc] = s[W-1:0];
      xc[cyc] = |s[W+1:W];
      clr[k] = 1'b1;
      mptr = (k + 1) % N;
    end
    chk_dut(0, "l0", av0, az0, aa0, ab0, rv0, rd0, rc0, bsy0);
    chk_dut(2, "l2", av2, az2, aa2, ab2, rv2, rd2, rc2, bsy2);
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (!hold_all) pend = pend & ~clr;
    clr = '0;
    vld = pend;
  endtask

  task automatic set_req(input logic [N-1:0] m);
    pend = m;
    vld = m;
  endtask

  task automatic set_ops(input int k, input logic [W-1:0] z, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    rz[k*W +: W] = z;
    ra[k*W +: W] = a;
    rb[k*W +: W] = b;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    logic [N-1:0] g [8];
    logic [N-1:0] r [8];
    int npulse;

    repeat (3) step();
    @(negedge clk);
    chk("reset_add_vld", av2, 0);
    chk("reset_res_vld", rv2, 0);
    chk("reset_busy", bsy2, 0);

    // Single request from requester 0: 1+2+3
    step(); rstn = 1'b1; en = 1'b1; set_ops(0, 1, 2, 3); set_req(4'b0001);
    @(negedge clk); chk("one_rdy", rdy0, 4'b0001);
    step(); @(negedge clk); chk("one_add_vld", av0, 1); chk("one_add_b", ab0, 3);
    step(); @(negedge clk);
    chk("one_res_vld_l0", rv0, 4'b0001); chk("one_res_d_l0", rd0, 6); chk("one_res_c_l0", rc0, 0);
    step(); step(); @(negedge clk);
    chk("one_res_vld_l2", rv2, 4'b0001); chk("one_res_d_l2", rd2, 6);
    repeat (2) step();

    // Re-centre the pointer, then all four requesters held valid for 8 cycles
    step(); rstn = 1'b0;
    step(); rstn = 1'b1;
    step();
    for (int k = 0; k < N; k++) set_ops(k, W'(k + 1), W'(16 * k), W'(32'h100 << k));
    hold_all = 1'b1;
    set_req(4'b1111);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      if (i == 8) begin
        hold_all = 1'b0;
        set_req('0);
      end
      @(negedge clk);
      if (i < 8) g[i] = rdy0;
      if (i >= 2) r[i-2] = rv0;
    end
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rr_grant%0d", i), g[i], N'(1) << (i % 4));
      chk($sformatf("rr_result%0d", i), r[i], N'(1) << (i % 4));
    end
    repeat (2) step();

    // Requester 2 with all-ones operands (pointer is 0 here)
    step(); set_ops(2, '1, '1, '1); set_req(4'b0100);
    @(negedge clk); chk("ovf_rdy", rdy2, 4'b0100);
    step(); step(); @(negedge clk);
    chk("ovf_res_vld_l0", rv0, 4'b0100); chk("ovf_res_d_l0", rd0, c_ovf_d); chk("ovf_res_c_l0", rc0, 1);
    step(); step(); @(negedge clk);
    chk("ovf_res_vld_l2", rv2, 4'b0100); chk("ovf_res_d_l2", rd2, c_ovf_d); chk("ovf_res_c_l2", rc2, 1);
    step();

    // Wrap: pointer is 3, only requester 0 valid; then 1 and 3 compete
    step(); set_req(4'b0001);
    @(negedge clk); chk("wrap_rdy", rdy0, 4'b0001);
    step(); set_req(4'b1010);
    @(negedge clk); chk("wrap_next_rdy", rdy0, 4'b0010);
    step(); @(negedge clk); chk("wrap_then_rdy", rdy0, 4'b1000);
    repeat (6) step();

    // Enable drops after the first of three pending issues
    step(); set_req(4'b0111);
    @(negedge clk); chk("en_first_rdy", rdy2, 4'b0001);
    step(); en = 1'b0;
    @(negedge clk); chk("en_off_rdy", rdy2, 4'b0000);
    step(); @(negedge clk); chk("en_busy_t2", bsy2, 1);
    step(); @(negedge clk); chk("en_busy_t3", bsy2, 1); chk("en_res_t3", rv2, 4'b0000);
    step(); @(negedge clk); chk("en_res_t4", rv2, 4'b0001); chk("en_busy_t4", bsy2, 0);
    step(); @(negedge clk); chk("en_res_t5", rv2, 4'b0000);
    step(); set_req('0); en = 1'b1;
    repeat (4) step();

    // Reset with two issues in flight (pointer is 1 here)
    step(); set_req(4'b0011);
    @(negedge clk); chk("rst_first_rdy", rdy2, 4'b0010);
    step(); @(negedge clk); chk("rst_second_rdy", rdy2, 4'b0001);
    step(); rstn = 1'b0; set_req('0);
    @(negedge clk);
    chk("rst_add_vld", av2, 0); chk("rst_add_z", az2, 0);
    chk("rst_busy", bsy2, 0); chk("rst_res_vld", rv2, 0);
    step(); rstn = 1'b1;
    npulse = 0;
    repeat (8) begin
      step();
      @(negedge clk);
      if (rv2 != '0) npulse++;
      if (rv0 != '0) npulse++;
    end
    chk("rst_no_late_result", npulse, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
